// File: rtl/srt_div_arbiter.sv
// rtl/srt_div_arbiter.sv - two-requester round-robin front end for a shared multi-cycle divider
module srt_div_arbiter #(
    parameter int DATA_WIDTH  = 8,
    parameter int DIV_LATENCY = 7
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req0_valid,
    input  logic [DATA_WIDTH-1:0] req0_dividend,
    input  logic [DATA_WIDTH-1:0] req0_divisor,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [DATA_WIDTH-1:0] req1_dividend,
    input  logic [DATA_WIDTH-1:0] req1_divisor,
    output logic                  req1_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [DATA_WIDTH-1:0] rsp_quotient,
    output logic [DATA_WIDTH-1:0] rsp_remainder,
    output logic                  rsp_ov,
    output logic                  div_enable_out,
    output logic [DATA_WIDTH-1:0] div_dividend,
    output logic [DATA_WIDTH-1:0] div_divisor,
    input  logic [DATA_WIDTH-1:0] div_quotient,
    input  logic [DATA_WIDTH-1:0] div_remainder,
    input  logic                  div_ov_flag
);

    localparam int CNT_W = $clog2(DIV_LATENCY) + 1;

    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_ISSUE = 4'b0010,
        S_WAIT  = 4'b0100,
        S_RESP  = 4'b1000
    } state_t;

    state_t                r_state;
    logic                  r_last_grant;
    logic                  r_req_id;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_dividend;
    logic [DATA_WIDTH-1:0] r_divisor;

    logic                  w_accept;
    logic                  w_grant1;
    logic [DATA_WIDTH-1:0] w_sel_dividend;
    logic [DATA_WIDTH-1:0] w_sel_divisor;

    // On a tie the requester that did not win last time gets the grant.
    assign w_grant1       = req1_valid && (!req0_valid || !r_last_grant);
    assign w_accept       = (r_state == S_IDLE) && (req0_valid || req1_valid);
    assign req0_ready     = w_accept && !w_grant1;
    assign req1_ready     = w_accept && w_grant1;
    assign w_sel_dividend = w_grant1 ? req1_dividend : req0_dividend;
    assign w_sel_divisor  = w_grant1 ? req1_divisor  : req0_divisor;

    assign div_dividend   = r_dividend;
    assign div_divisor    = r_divisor;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_last_grant   <= 1'b1;
            r_req_id       <= 1'b0;
            r_cnt          <= '0;
            r_dividend     <= '0;
            r_divisor      <= '0;
            rsp_valid      <= 1'b0;
            rsp_id         <= 1'b0;
            rsp_quotient   <= '0;
            rsp_remainder  <= '0;
            rsp_ov         <= 1'b0;
            div_enable_out <= 1'b0;
        end else begin
            div_enable_out <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_dividend   <= w_sel_dividend;
                        r_divisor    <= w_sel_divisor;
                        r_req_id     <= w_grant1;
                        r_last_grant <= w_grant1;
                        // Divide-by-zero is answered locally without starting the divider.
                        if (w_sel_divisor == '0) begin
                            rsp_valid     <= 1'b1;
                            rsp_id        <= w_grant1;
                            rsp_quotient  <= '1;
                            rsp_remainder <= w_sel_dividend;
                            rsp_ov        <= 1'b1;
                            r_state       <= S_RESP;
                        end else begin
                            div_enable_out <= 1'b1;
                            r_state        <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= CNT_W'(DIV_LATENCY);
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        rsp_valid     <= 1'b1;
                        rsp_id        <= r_req_id;
                        rsp_quotient  <= div_quotient;
                        rsp_remainder <= div_remainder;
                        rsp_ov        <= div_ov_flag;
                        r_state       <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/srt_div_arbiter.md
SRT_DIV_ARBITER -- requirements
Module: srt_div_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8: operand and result width.
REQ-002 Parameter DIV_LATENCY, default 7: cycles from the divider enable pulse until the divider's quotient, remainder and ov_flag are valid; the divider holds them until its next enable.
REQ-003 clk  in  1  single clock; all state is updated on its rising edge.
REQ-004 reset_n  in  1  reset, asynchronous and active-low.
REQ-005 reqN_valid  in  1  request pending from requester N (N = 0, 1).
REQ-006 reqN_dividend, reqN_divisor  in  DATA_WIDTH each  requester N's unsigned operands.
REQ-007 reqN_ready  out  1  requester N's request is accepted this cycle when reqN_valid is also high.
REQ-008 rsp_valid  out  1  response held valid.
REQ-009 rsp_ready  in  1  consumer accepts the response.
REQ-010 rsp_id  out  1  index of the requester the response belongs to.
REQ-011 rsp_quotient, rsp_remainder  out  DATA_WIDTH each  division result.
REQ-012 rsp_ov  out  1  divide-by-zero flag.
REQ-013 div_enable_out  out  1  single-cycle start pulse to the shared divider.
REQ-014 div_dividend, div_divisor  out  DATA_WIDTH each  divider operands.
REQ-015 div_quotient, div_remainder  in  DATA_WIDTH each  divider results.
REQ-016 div_ov_flag  in  1  divider overflow flag.

Function
REQ-017 FSM shall be one-hot with states S_IDLE, S_ISSUE, S_WAIT and S_RESP; any illegal encoding shall return to S_IDLE on the next cycle.
REQ-018 Outside S_IDLE, req0_ready and req1_ready shall both be 0.
REQ-019 In S_IDLE, exactly one reqN_ready shall be 1 when any reqN_valid is 1, and both shall be 0 otherwise.
- Only one valid: that requester wins.
- Both valid: the requester not granted last wins (round-robin).
- last_grant updates only on acceptance.
REQ-020 On acceptance, the block shall latch dividend, divisor and requester index into internal registers.
REQ-021 Accept with divisor == 0: next state S_RESP, divider not started.
- rsp_quotient = all ones, rsp_remainder = latched dividend, rsp_ov = 1.
REQ-022 Accept with divisor != 0: next state S_ISSUE.
REQ-023 S_ISSUE shall last one cycle:
- div_enable_out = 1.
- Latched operands driven on div_dividend and div_divisor.
- Wait counter loaded with DIV_LATENCY.
- Next state S_WAIT.
REQ-024 div_dividend and div_divisor shall hold the latched operands in every state; div_enable_out shall be 0 outside S_ISSUE.
REQ-025 S_WAIT shall decrement the counter each cycle. When the counter equals 1:
- Capture div_quotient, div_remainder and div_ov_flag into the rsp registers.
- Next state S_RESP.
REQ-026 rsp_valid shall be 1 exactly in S_RESP, rising DIV_LATENCY+2 cycles after the accept cycle for nonzero divisors and 1 cycle after it for zero divisors.
REQ-027 In S_RESP, rsp_id, rsp_quotient, rsp_remainder and rsp_ov shall stay stable while rsp_ready = 0.
REQ-028 rsp_valid && rsp_ready shall return the FSM to S_IDLE next cycle; a new request may be accepted in that S_IDLE cycle.
REQ-029 Requests arriving during S_ISSUE, S_WAIT or S_RESP shall not be accepted; the requester keeps valid asserted and is arbitrated in the next S_IDLE.
REQ-030 rsp registers shall keep their last values after the handshake until overwritten.
REQ-031 The wait counter width shall be clog2(DIV_LATENCY)+1 bits.

Reset
REQ-032 reset_n low shall asynchronously force:
- FSM to S_IDLE, last_grant = 1 (so req0 wins the first tie).
- Wait counter 0, latched operands 0.
- rsp_valid 0, rsp_id 0, rsp_quotient 0, rsp_remainder 0, rsp_ov 0.
- div_enable_out 0.
REQ-033 Reset asserted mid-operation shall abandon the transaction with no response issued; the first request after release shall be handled normally.

Verification
REQ-034 req0 100/7, rsp_ready=1 -> div_enable_out one pulse in the cycle after accept; rsp_valid 9 cycles after accept; id 0, q 14, r 2, ov 0.
REQ-035 req0 and req1 valid together from reset, each reissued after its response -> grant order 0, 1, 0, 1; rsp_id alternates.
REQ-036 req1 200/0 -> no div_enable_out; rsp_valid 1 cycle after accept; q 0xFF, r 200, ov 1.
REQ-037 rsp_ready held 0 for 5 cycles in S_RESP -> rsp fields stable; req0_ready and req1_ready stay 0; acceptance happens 1 cycle after rsp_ready rises.
REQ-038 reset_n pulsed low during S_WAIT -> all outputs 0 immediately; no rsp_valid for the abandoned job; next request 255/16 -> q 15, r 15.
